frame_diff_writer: RTL and testbench

Pipelined frame-differencing stage between the video-in pixel stream and the binary-difference (bdiff) frame buffer consumed by the display/erosion/centroid stage. Each accepted pixel:
- reads the co-located pixel of the previous frame from the prev-image RAM;
- writes the current pixel back to that RAM;
- writes a 1-bit difference flag to the bdiff RAM at the same address.
Also reports per-frame change count and frame-done pulse.

---
 rtl/frame_diff_writer_if.sv | 35 +++
 rtl/frame_diff_writer.sv | 106 ++++++++++
 tb/tb_frame_diff_writer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_diff_writer_if.sv
// frame_diff_writer_if: pixel stream plus prev-image and bdiff RAM ports of the frame differencer.
//   pix_en/pix_x/pix_y/pix_colour : incoming pixel strobe, coordinates and value
//   prev_rdaddress/prev_q         : prev-image read port (q one cycle after address)
//   prev_wraddress/prev_data/prev_wren : prev-image write port
//   bdiff_wraddress/bdiff_data/bdiff_wren : binary-difference write port
//   master = pixel source / RAM side, slave = frame_diff_writer
interface frame_diff_writer_if #(
    parameter int COLOUR_WIDTH = 3,
    parameter int ADDR_WIDTH   = 17
);
    logic                    pix_en;
    logic [8:0]              pix_x;
    logic [7:0]              pix_y;
    logic [COLOUR_WIDTH-1:0] pix_colour;
    logic [ADDR_WIDTH-1:0]   prev_rdaddress;
    logic [COLOUR_WIDTH-1:0] prev_q;
    logic [ADDR_WIDTH-1:0]   prev_wraddress;
    logic [COLOUR_WIDTH-1:0] prev_data;
    logic                    prev_wren;
    logic [ADDR_WIDTH-1:0]   bdiff_wraddress;
    logic                    bdiff_data;
    logic                    bdiff_wren;

    modport master (
        output pix_en, pix_x, pix_y, pix_colour, prev_q,
        input  prev_rdaddress, prev_wraddress, prev_data, prev_wren,
        input  bdiff_wraddress, bdiff_data, bdiff_wren
    );

    modport slave (
        input  pix_en, pix_x, pix_y, pix_colour, prev_q,
        output prev_rdaddress, prev_wraddress, prev_data, prev_wren,
        output bdiff_wraddress, bdiff_data, bdiff_wren
    );
endinterface

// File: rtl/frame_diff_writer.sv
// frame_diff_writer: 3-stage pipeline comparing each pixel against the previous frame and writing bdiff flags.
//   clock, resetn (async, active low)
//   bus         : pixel stream in, prev-image RAM read/write, bdiff RAM write
//   diff_mode   : 1 = flag on any mismatch, 0 = flag = previous-frame bit chan_sel
//   chan_sel    : bit index for debug view (out-of-range index gives 0)
//   diff_count  : flagged-pixel total of the last completed frame
//   frame_done  : one-cycle pulse after the last pixel of a frame is written
//   frame_valid : high once a full frame has populated the prev-image RAM
module frame_diff_writer #(
    parameter int IMAGE_W      = 320,
    parameter int IMAGE_H      = 240,
    parameter int COLOUR_WIDTH = 3,
    parameter int ADDR_WIDTH   = 17
) (
    input  logic                  clock,
    input  logic                  resetn,
    frame_diff_writer_if.slave    bus,
    input  logic                  diff_mode,
    input  logic [1:0]            chan_sel,
    output logic [ADDR_WIDTH-1:0] diff_count,
    output logic                  frame_done,
    output logic                  frame_valid
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE_W * IMAGE_H - 1);

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   addr_in;
    logic                    s0_valid;
    logic [ADDR_WIDTH-1:0]   s0_addr;
    logic [COLOUR_WIDTH-1:0] s0_colour;
    logic                    s1_valid;
    logic [ADDR_WIDTH-1:0]   s1_addr;
    logic [COLOUR_WIDTH-1:0] s1_colour;
    logic                    wren;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [COLOUR_WIDTH-1:0] wr_colour;
    logic                    wr_flag;
    logic [COLOUR_WIDTH-1:0] prev_val;
    logic [COLOUR_WIDTH-1:0] prev_shift;
    logic                    flag;
    logic                    last_write;
    logic [ADDR_WIDTH-1:0]   run_count;
    logic [ADDR_WIDTH-1:0]   count_sum;

    assign bus.prev_rdaddress  = s0_addr;
    assign bus.prev_wraddress  = wr_addr;
    assign bus.prev_data       = wr_colour;
    assign bus.prev_wren       = wren;
    assign bus.bdiff_wraddress = wr_addr;
    assign bus.bdiff_data      = wr_flag;
    assign bus.bdiff_wren      = wren;

    always_comb begin
        accept     = bus.pix_en && (32'(bus.pix_x) < IMAGE_W) && (32'(bus.pix_y) < IMAGE_H);
        addr_in    = ADDR_WIDTH'(32'(bus.pix_y) * IMAGE_W + 32'(bus.pix_x));
        // The write now on the RAM port lands after this stage's read was sampled, so bypass it.
        prev_val   = (wren && wr_addr == s1_addr) ? wr_colour : bus.prev_q;
        // Shifting rather than indexing makes chan_sel >= COLOUR_WIDTH read as 0.
        prev_shift = prev_val >> chan_sel;
        flag       = frame_valid && (diff_mode ? (prev_val != s1_colour) : prev_shift[0]);
        last_write = wren && wr_addr == LAST_ADDR;
        count_sum  = (wr_flag && !(&run_count)) ? run_count + ADDR_WIDTH'(1) : run_count;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s0_valid    <= 1'b0;
            s0_addr     <= '0;
            s0_colour   <= '0;
            s1_valid    <= 1'b0;
            s1_addr     <= '0;
            s1_colour   <= '0;
            wren        <= 1'b0;
            wr_addr     <= '0;
            wr_colour   <= '0;
            wr_flag     <= 1'b0;
            run_count   <= '0;
            diff_count  <= '0;
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            s0_valid <= accept;
            if (accept) begin
                s0_addr   <= addr_in;
                s0_colour <= bus.pix_colour;
            end
            s1_valid  <= s0_valid;
            s1_addr   <= s0_addr;
            s1_colour <= s0_colour;
            wren      <= s1_valid;
            wr_flag   <= s1_valid && flag;
            if (s1_valid) begin
                wr_addr   <= s1_addr;
                wr_colour <= s1_colour;
            end
            frame_done <= last_write;
            if (last_write) begin
                diff_count  <= count_sum;
                run_count   <= '0;
                frame_valid <= 1'b1;
            end else begin
                run_count <= count_sum;
            end
        end
    end
endmodule

// File: tb/tb_frame_diff_writer.sv
// tb_frame_diff_writer: scoreboard bench for frame_diff_writer with a behavioural prev-image RAM and a latest-value reference model.
module tb_frame_diff_writer;
    localparam int W    = 320;
    localparam int H    = 4;
    localparam int CW   = 3;
    localparam int AW   = 17;
    localparam int LAST = W * H - 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] colour;
        logic          flag;
    } wr_t;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          diff_mode = 1'b1;
    logic [1:0]    chan_sel = 2'd0;
    logic [AW-1:0] diff_count;
    logic          frame_done;
    logic          frame_valid;

    logic [CW-1:0] ram [0:2**AW-1];
    logic [CW-1:0] mm  [0:2**AW-1];
    logic          fv_m = 1'b0;
    logic [AW-1:0] run_m = '0;
    wr_t           sb[$];
    logic [AW-1:0] dcq[$];
    wr_t           e;
    logic          fd_q = 1'b0;
    int            n_vec = 0;
    int            n_err = 0;
    int            n_done = 0;

    frame_diff_writer_if #(.COLOUR_WIDTH(CW), .ADDR_WIDTH(AW)) ifc ();

    frame_diff_writer #(
        .IMAGE_W(W), .IMAGE_H(H), .COLOUR_WIDTH(CW), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(ifc),
        .diff_mode(diff_mode),
        .chan_sel(chan_sel),
        .diff_count(diff_count),
        .frame_done(frame_done),
        .frame_valid(frame_valid)
    );

    always #5 clock = ~clock;

    // Prev-image RAM: registered read, write-through when read and write hit the same address.
    always @(posedge clock) begin
        ifc.prev_q <= (ifc.prev_wren && ifc.prev_wraddress == ifc.prev_rdaddress) ? ifc.prev_data : ram[ifc.prev_rdaddress];
        if (ifc.prev_wren) ram[ifc.prev_wraddress] <= ifc.prev_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic px(input int x, input int y, input logic [CW-1:0] c, input bit track);
        logic [AW-1:0] a;
        logic [CW-1:0] p;
        logic [CW-1:0] sh;
        logic          f;
        ifc.pix_en     = 1'b1;
        ifc.pix_x      = x[8:0];
        ifc.pix_y      = y[7:0];
        ifc.pix_colour = c;
        if (track && x < W && y < H) begin
            a  = AW'(y * W + x);
            p  = mm[a];
            sh = p >> chan_sel;
            f  = fv_m && (diff_mode ? (p != c) : sh[0]);
            mm[a] = c;
            sb.push_back('{a, c, f});
            if (f) run_m++;
            if (a == LAST) begin
                dcq.push_back(run_m);
                run_m = '0;
                fv_m  = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        ifc.pix_en = 1'b0;
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            if (ifc.prev_wren || ifc.bdiff_wren) begin
                if (sb.size() == 0) begin
                    chk("spurious_write", ifc.prev_wren | ifc.bdiff_wren, 0);
                end else begin
                    e = sb.pop_front();
                    chk("prev_wren", ifc.prev_wren, 1);
                    chk("bdiff_wren", ifc.bdiff_wren, 1);
                    chk("prev_wraddress", ifc.prev_wraddress, e.addr);
                    chk("bdiff_wraddress", ifc.bdiff_wraddress, e.addr);
                    chk("prev_data", ifc.prev_data, e.colour);
                    chk("bdiff_data", ifc.bdiff_data, e.flag);
                end
            end
            if (fd_q) chk("frame_done_width", frame_done, 0);
            if (frame_done) begin
                n_done++;
                if (dcq.size() == 0) chk("spurious_done", frame_done, 0);
                else chk("diff_count", diff_count, dcq.pop_front());
            end
            fd_q <= frame_done;
        end
    end

    initial begin
        ifc.pix_en = 1'b0;
        ifc.pix_x = '0;
        ifc.pix_y = '0;
        ifc.pix_colour = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_prev_wren", ifc.prev_wren, 0);
        chk("rst_bdiff_wren", ifc.bdiff_wren, 0);
        chk("rst_rdaddress", ifc.prev_rdaddress, 0);
        chk("rst_diff_count", diff_count, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        resetn = 1'b1;
        idle(2);

        px(1, 0, 3'b110, 0);
        px(2, 0, 3'b011, 0);
        idle(1);
        chk("pre_rst_wren", ifc.prev_wren, 1);
        resetn = 1'b0;
        #1;
        chk("async_rst_prev_wren", ifc.prev_wren, 0);
        chk("async_rst_bdiff_wren", ifc.bdiff_wren, 0);
        idle(1);
        resetn = 1'b1;
        idle(4);
        chk("post_rst_diff_count", diff_count, 0);
        chk("post_rst_frame_valid", frame_valid, 0);

        px(5, 2, 3'b101, 1);
        chk("lat_rdaddress", ifc.prev_rdaddress, 645);
        idle(1);
        chk("lat_n1_wren", ifc.prev_wren, 0);
        idle(1);
        chk("lat_wren", ifc.bdiff_wren, 1);
        chk("lat_wraddress", ifc.prev_wraddress, 645);
        chk("lat_data", ifc.prev_data, 3'b101);
        chk("lat_flag", ifc.bdiff_data, 0);
        idle(2);

        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                px(x, y, 3'b000, 1);
        idle(4);
        chk("f1_frame_valid", frame_valid, 1);
        chk("f1_diff_count", diff_count, 0);

        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                px(x, y, ((y * W + x) % 97 == 11 && (y * W + x) < 970) ? 3'b010 : 3'b000, 1);
        idle(4);
        chk("f2_diff_count", diff_count, 10);

        px(100, 0, 3'b001, 1);
        idle(3);
        px(100, 0, 3'b001, 1);
        px(100, 0, 3'b011, 1);
        idle(3);
        px(100, 0, 3'b001, 1);
        idle(3);
        px(100, 0, 3'b011, 1);
        px(100, 0, 3'b011, 1);
        idle(3);

        diff_mode = 1'b0;
        chan_sel = 2'd1;
        px(200, 0, 3'b010, 1);
        px(200, 0, 3'b111, 1);
        idle(3);
        chan_sel = 2'd3;
        px(200, 0, 3'b010, 1);
        px(200, 0, 3'b111, 1);
        idle(3);
        chan_sel = 2'd2;
        px(200, 0, 3'b000, 1);
        idle(3);
        diff_mode = 1'b1;
        chan_sel = 2'd0;

        px(320, 0, 3'b111, 1);
        px(0, 240, 3'b111, 1);
        px(319, 4, 3'b111, 1);
        chk("range_prev_wren", ifc.prev_wren, 0);
        idle(1);
        chk("range_bdiff_wren", ifc.bdiff_wren, 0);
        idle(2);

        px(319, 3, 3'b110, 1);
        px(0, 0, 3'b111, 1);
        idle(4);
        px(319, 3, 3'b110, 1);
        idle(4);
        chk("final_diff_count", diff_count, 1);
        chk("final_frame_valid", frame_valid, 1);

        chk("sb_empty", sb.size(), 0);
        chk("dc_empty", dcq.size(), 0);
        chk("done_pulses", n_done, 4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
